prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Upstream instruction-supply stage for the Femto core; it feeds the 7-bit instruction word consumed by the core's decode/execute path.
- Fill phase: the host loads a short program from the pin interface into a small buffer.
- Run phase: the block replays the program cyclically, one instruction per clock, with a valid flag.
- It adds wrap-around, resumable PC, clear, and overflow reporting.

Parameters:
- DEPTH, 6, number of instruction entries (2..16).
- IW, 7, instruction width in bits.
- AW, 3, pointer width; must satisfy 2**AW >= DEPTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  requested mode: 00 idle, 01 run, 10 fill, 11 clear.
- wr_valid  input  1  instr_in is to be written (fill mode only).
- instr_in  input  IW  instruction word to store.
- instr_out  output  IW  instruction presented to the core.
- instr_valid  output  1  instr_out is a live instruction this cycle.
- pc  output  AW  index of the next entry to issue.
- count  output  AW+1  number of stored instructions.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; a write was attempted while full.

Behaviour:
- Reset (async, rst_n low) sets:
  - state = IDLE; wptr, pc, count = 0.
  - instr_out = 0 (opcode 000, no register write in the core); instr_valid = 0; overflow = 0.
  - Buffer contents are not reset.
- State register: state <= decode(mode) every clock. Actions are taken based on the registered state, so a mode change takes effect one cycle after it is sampled.
- IDLE: nothing changes except that instr_valid and instr_out are driven to 0.
- FILL:
  - wr_valid=1 and !full: mem[wptr] <= instr_in; wptr++; count++.
  - wr_valid=1 and full: write is dropped and overflow <= 1.
  - Entering FILL appends after the existing contents; it does not clear them.
  - instr_valid = 0.
- RUN:
  - count == 0: instr_valid <= 0, instr_out <= 0, pc unchanged.
  - Otherwise, each cycle: instr_out <= mem[pc]; instr_valid <= 1; pc <= (pc == count-1) ? 0 : pc+1.
  - First valid instruction appears one cycle after state becomes RUN, i.e. two edges after mode=01 is applied.
- Leaving RUN: instr_valid and instr_out go to 0 on the next edge. pc is held, so re-entering RUN resumes at the held pc.
- CLEAR:
  - wptr, pc, count and overflow are set to 0.
  - The buffer is not erased, but all entries are logically discarded.
  - Held for as long as mode=11.
- wr_valid is ignored in every state other than FILL.
- full and count are combinational from the count register.
- Invariants: pc < count whenever count > 0; wptr == count (mod 2**AW).
- Reset asserted mid-RUN: outputs drop to their reset values immediately (async). The program is logically lost because count = 0.

Optional Feature:
- Macro: PROG_SEQUENCER_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - In RUN, an instruction issues (instr_out/instr_valid update, pc advances) only in cycles where step=1.
  - In RUN cycles with step=0: instr_valid <= 0, instr_out <= 0, pc held.
  - All other states are unaffected by step.
- Undefined: no step port; RUN is free-running as described above.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-activity -> instr_valid=0, instr_out=0, count=0, pc=0, overflow=0 while rst_n is low (asynchronous).
- Fill: mode=10, write 0x11, 0x22, 0x33 with wr_valid=1 -> count=3, full=0. Then mode=01 -> after 2 edges, instr_out sequence 0x11, 0x22, 0x33, 0x11, 0x22 with instr_valid=1; pc wraps 2 -> 0.
- Full/overflow: write 6 words -> full=1. 7th write (0x7F) -> count stays 6, overflow=1. RUN never issues 0x7F.
- Resume: RUN issues 0x11 then 0x22; switch to mode=00 for 3 cycles -> instr_valid=0. Return to 01 -> next issued word is 0x33.
- Clear/empty: mode=11 for 1 cycle -> count=0, overflow=0. Then mode=01 -> instr_valid stays 0. Fill a single 0x05, run -> 0x05 issued every cycle.
- Step (macro defined): RUN with 3 words, step pulses in cycles 1, 4, 5 -> instr_valid=1 only one cycle after each pulse, issuing words 0, 1, 2 in order.

Source files
------------

// File: rtl/prog_sequencer_if.sv
// Host/core-facing bus of prog_sequencer: fill/run control in, instruction stream out.
// The optional step input exists only when PROG_SEQUENCER_STEP_EN is defined.
interface prog_sequencer_if #(
    parameter int IW = 7,
    parameter int AW = 3
);
    logic [1:0]    mode;
    logic          wr_valid;
    logic [IW-1:0] instr_in;
`ifdef PROG_SEQUENCER_STEP_EN
    logic          step;
`endif
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic [AW:0]   count;
    logic          full;
    logic          overflow;

    modport master (
`ifdef PROG_SEQUENCER_STEP_EN
        output step,
`endif
        output mode, wr_valid, instr_in,
        input  instr_out, instr_valid, pc, count, full, overflow
    );

    modport slave (
`ifdef PROG_SEQUENCER_STEP_EN
        input  step,
`endif
        input  mode, wr_valid, instr_in,
        output instr_out, instr_valid, pc, count, full, overflow
    );
endinterface

// File: rtl/prog_sequencer.sv
// Instruction supply for the Femto core: fill a small program buffer, then replay it cyclically.
// Optional macro PROG_SEQUENCER_STEP_EN gates each RUN issue on bus.step.
module prog_sequencer #(
    parameter int DEPTH = 6,
    parameter int IW    = 7,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    prog_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FILL  = 2'b10,
        ST_CLEAR = 2'b11
    } state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] pc;
    logic [AW:0]   count;
    logic          overflow;
    logic [IW-1:0] instr_out;
    logic          instr_valid;

    // Buffer contents survive reset and clear; count alone defines what is live.
    logic [IW-1:0] mem [DEPTH];

    logic full;
    logic wr_en;
    logic issue;
    logic pc_last;
    logic step_ok;

    function automatic state_t decode_mode(input logic [1:0] m);
        state_t s;
        case (m)
            2'b01:   s = ST_RUN;
            2'b10:   s = ST_FILL;
            2'b11:   s = ST_CLEAR;
            default: s = ST_IDLE;
        endcase
        return s;
    endfunction

    always_comb begin
`ifdef PROG_SEQUENCER_STEP_EN
        step_ok = bus.step;
`else
        step_ok = 1'b1;
`endif
        full    = (count == DEPTH_C);
        wr_en   = (state == ST_FILL) && bus.wr_valid && !full;
        issue   = (state == ST_RUN) && (count != '0) && step_ok;
        pc_last = ({1'b0, pc} == (count - CNT_ONE));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= bus.instr_in;
        end
    end

    // Actions follow the registered state, so a mode change lands one edge after it is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wptr        <= '0;
            pc          <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= decode_mode(bus.mode);
            instr_out   <= '0;
            instr_valid <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (bus.wr_valid) begin
                        if (!full) begin
                            wptr  <= wptr + PTR_ONE;
                            count <= count + CNT_ONE;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        instr_out   <= mem[pc];
                        instr_valid <= 1'b1;
                        pc          <= pc_last ? '0 : pc + PTR_ONE;
                    end
                end
                ST_CLEAR: begin
                    wptr     <= '0;
                    pc       <= '0;
                    count    <= '0;
                    overflow <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.instr_out   = instr_out;
    assign bus.instr_valid = instr_valid;
    assign bus.pc          = pc;
    assign bus.count       = count;
    assign bus.full        = full;
    assign bus.overflow    = overflow;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed vector bench for prog_sequencer: fill, run, wrap, resume, clear, overflow, async reset.
// Builds with or without PROG_SEQUENCER_STEP_EN.
module tb_prog_sequencer;

    localparam int DEPTH = 6;
    localparam int IW    = 7;
    localparam int AW    = 3;

    logic clk;
    logic rst_n;

    prog_sequencer_if #(.IW(IW), .AW(AW)) bus ();

    prog_sequencer #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    mode;
        logic          wr;
        logic [IW-1:0] din;
        logic          ev;
        logic [IW-1:0] eout;
        logic [AW-1:0] epc;
        logic [AW:0]   ecnt;
        logic          eovf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef PROG_SEQUENCER_STEP_EN
    logic          st_step  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [IW-1:0] st_out   [6] = '{7'h00, 7'h0A, 7'h00, 7'h00, 7'h0B, 7'h0D};
    logic [AW-1:0] st_pc    [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd0};
`endif

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] mode, input logic wr, input logic [IW-1:0] din,
                       input logic ev, input logic [IW-1:0] eout, input logic [AW-1:0] epc,
                       input logic [AW:0] ecnt, input logic eovf);
        vec_t v;
        v.mode = mode; v.wr = wr; v.din = din;
        v.ev = ev; v.eout = eout; v.epc = epc; v.ecnt = ecnt; v.eovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input int idx, input logic ev, input logic [IW-1:0] eout,
                             input logic [AW-1:0] epc, input logic [AW:0] ecnt, input logic eovf);
        check({tag, ".valid"}, idx, 32'(bus.instr_valid), 32'(ev));
        check({tag, ".out"},   idx, 32'(bus.instr_out),   32'(eout));
        check({tag, ".pc"},    idx, 32'(bus.pc),          32'(epc));
        check({tag, ".count"}, idx, 32'(bus.count),       32'(ecnt));
        check({tag, ".full"},  idx, 32'(bus.full),        32'(ecnt == (AW+1)'(DEPTH)));
        check({tag, ".ovf"},   idx, 32'(bus.overflow),    32'(eovf));
    endtask

    initial begin
        // Fill 3 words, run 5 issues with wrap
        add(2'b10, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        add(2'b10, 1'b1, 7'h11, 1'b0, 7'h00, 3'd0, 4'd1, 1'b0);
        add(2'b10, 1'b1, 7'h22, 1'b0, 7'h00, 3'd0, 4'd2, 1'b0);
        add(2'b10, 1'b1, 7'h33, 1'b0, 7'h00, 3'd0, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h11, 3'd1, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h22, 3'd2, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h33, 3'd0, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h11, 3'd1, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h22, 3'd2, 4'd3, 1'b0);
        add(2'b00, 1'b0, 7'h00, 1'b1, 7'h33, 3'd0, 4'd3, 1'b0);
        add(2'b00, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd3, 1'b0);
        // Resume: issue 0x11, 0x22, idle 3 cycles, next issue is 0x33
        add(2'b01, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h11, 3'd1, 4'd3, 1'b0);
        add(2'b00, 1'b0, 7'h00, 1'b1, 7'h22, 3'd2, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++)
            add(2'b00, 1'b0, 7'h00, 1'b0, 7'h00, 3'd2, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b0, 7'h00, 3'd2, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h33, 3'd0, 4'd3, 1'b0);
        // Clear for one cycle, empty run, single-entry program
        add(2'b11, 1'b0, 7'h00, 1'b1, 7'h11, 3'd1, 4'd3, 1'b0);
        add(2'b00, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        add(2'b10, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        add(2'b10, 1'b1, 7'h05, 1'b0, 7'h00, 3'd0, 4'd1, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd1, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h05, 3'd0, 4'd1, 1'b0);
        add(2'b01, 1'b1, 7'h7E, 1'b1, 7'h05, 3'd0, 4'd1, 1'b0);
        add(2'b11, 1'b0, 7'h00, 1'b1, 7'h05, 3'd0, 4'd1, 1'b0);
        // Full and overflow
        add(2'b10, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++)
            add(2'b10, 1'b1, 7'(8'h41 + i), 1'b0, 7'h00, 3'd0, 4'(i + 1), 1'b0);
        add(2'b10, 1'b1, 7'h7F, 1'b0, 7'h00, 3'd0, 4'd6, 1'b1);
        add(2'b01, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd6, 1'b1);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h41, 3'd1, 4'd6, 1'b1);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h42, 3'd2, 4'd6, 1'b1);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h43, 3'd3, 4'd6, 1'b1);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h44, 3'd4, 4'd6, 1'b1);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h45, 3'd5, 4'd6, 1'b1);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h46, 3'd0, 4'd6, 1'b1);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h41, 3'd1, 4'd6, 1'b1);
        add(2'b10, 1'b0, 7'h00, 1'b1, 7'h42, 3'd2, 4'd6, 1'b1);
        add(2'b11, 1'b0, 7'h00, 1'b0, 7'h00, 3'd2, 4'd6, 1'b1);
        add(2'b00, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        // Append across an idle gap; idle ignores wr_valid
        add(2'b10, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        add(2'b10, 1'b1, 7'h0A, 1'b0, 7'h00, 3'd0, 4'd1, 1'b0);
        add(2'b00, 1'b1, 7'h0B, 1'b0, 7'h00, 3'd0, 4'd2, 1'b0);
        add(2'b00, 1'b1, 7'h0C, 1'b0, 7'h00, 3'd0, 4'd2, 1'b0);
        add(2'b10, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd2, 1'b0);
        add(2'b10, 1'b1, 7'h0D, 1'b0, 7'h00, 3'd0, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b0, 7'h00, 3'd0, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h0A, 3'd1, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h0B, 3'd2, 4'd3, 1'b0);
        add(2'b01, 1'b0, 7'h00, 1'b1, 7'h0D, 3'd0, 4'd3, 1'b0);

        rst_n        = 1'b0;
        bus.mode     = 2'b00;
        bus.wr_valid = 1'b0;
        bus.instr_in = '0;
`ifdef PROG_SEQUENCER_STEP_EN
        bus.step     = 1'b1;
`endif
        #12;
        check_all("reset", 0, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.mode     = vecs[i].mode;
            bus.wr_valid = vecs[i].wr;
            bus.instr_in = vecs[i].din;
            @(posedge clk);
            #1;
            check_all("vec", i, vecs[i].ev, vecs[i].eout, vecs[i].epc, vecs[i].ecnt, vecs[i].eovf);
        end

`ifdef PROG_SEQUENCER_STEP_EN
        // Already in RUN with words 0x0A, 0x0B, 0x0D at pc 0
        for (int i = 0; i < 6; i++) begin
            bus.mode     = 2'b01;
            bus.wr_valid = 1'b0;
            bus.step     = st_step[i];
            @(posedge clk);
            #1;
            check_all("step", i, st_step[i], st_out[i], st_pc[i], 4'd3, 1'b0);
        end
        bus.step = 1'b1;
`endif

        // Asynchronous reset in the middle of a run
        bus.mode = 2'b01;
        @(posedge clk);
        #1;
        check("prerst.valid", 0, 32'(bus.instr_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("arst", 0, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("arst", 1, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_all("postrst", 0, 1'b0, 7'h00, 3'd0, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
